fp16_mul_result_stage: RTL and testbench

//  Registered output stage directly downstream of the combinational fp16 multiplier.

---
 rtl/fp16_mul_result_stage.sv | 102 ++++++++++
 tb/tb_fp16_mul_result_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_result_stage.sv
// rtl/fp16_mul_result_stage.sv - registered fp16 multiplier result stage
// Small FIFO with sNaN quieting, sticky status flags and saturating result counters.
module fp16_mul_result_stage #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_p,
   input  logic [5:0]       in_class,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_p,
   output logic [5:0]       out_class,
   input  logic             flags_clear,
   output logic             flag_invalid,
   output logic             flag_class_err,
   output logic [CNT_W-1:0] cnt_total,
   output logic [CNT_W-1:0] cnt_nan
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [15:0]   memP     [DEPTH];
   logic [5:0]    memClass [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   occupancy;

   logic          push;
   logic          pop;
   logic          isSnan;
   logic          isNan;
   logic          oneHot;
   logic [15:0]   storeP;
   logic [5:0]    storeClass;

   assign in_ready  = !reset && (occupancy < FULL_OCC);
   assign out_valid = (occupancy != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_p     = out_valid ? memP[rdPtr]     : 16'h0000;
   assign out_class = out_valid ? memClass[rdPtr] : 6'b000000;

   assign isSnan = in_class[5];
   assign isNan  = in_class[5] | in_class[4];
   assign oneHot = (in_class != 6'b000000) && ((in_class & (in_class - 6'd1)) == 6'b000000);

   // Quieting an sNaN keeps sign, exponent and payload; only the quiet bit is forced.
   assign storeP     = isSnan ? (in_p | 16'h0200) : in_p;
   assign storeClass = isSnan ? 6'b010000 : in_class;

   function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
      if (clr)
         return {{(CNT_W-1){1'b0}}, inc};
      else if (inc && (cur != CNT_MAX))
         return cur + CNT_W'(1);
      else
         return cur;
   endfunction

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         memP[wrPtr]     <= storeP;
         memClass[wrPtr] <= storeClass;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr          <= '0;
         rdPtr          <= '0;
         occupancy      <= '0;
         flag_invalid   <= 1'b0;
         flag_class_err <= 1'b0;
         cnt_total      <= '0;
         cnt_nan        <= '0;
      end else begin
         if (push)
            wrPtr <= wrPtr + AW'(1);
         if (pop)
            rdPtr <= rdPtr + AW'(1);
         case ({push, pop})
            2'b10:   occupancy <= occupancy + (AW+1)'(1);
            2'b01:   occupancy <= occupancy - (AW+1)'(1);
            default: occupancy <= occupancy;
         endcase
         flag_invalid   <= (flag_invalid   && !flags_clear) || (push && isSnan);
         flag_class_err <= (flag_class_err && !flags_clear) || (push && !oneHot);
         cnt_total      <= nextCount(cnt_total, push, flags_clear);
         cnt_nan        <= nextCount(cnt_nan, push && isNan, flags_clear);
      end
   end

endmodule

// File: tb/tb_fp16_mul_result_stage.sv
// tb/tb_fp16_mul_result_stage.sv - scoreboard bench for fp16_mul_result_stage
// Directed steps with a reference queue and flag/counter model.
module tb_fp16_mul_result_stage;

   localparam int DEPTH = 2;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_p;
   logic [5:0]       in_class;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_p;
   logic [5:0]       out_class;
   logic             flags_clear;
   logic             flag_invalid;
   logic             flag_class_err;
   logic [CNT_W-1:0] cnt_total;
   logic [CNT_W-1:0] cnt_nan;

   int nChecks = 0;
   int nErrors = 0;

   logic [21:0]      expQ[$];
   logic             mInvalid;
   logic             mClassErr;
   logic [CNT_W-1:0] mTotal;
   logic [CNT_W-1:0] mNan;

   fp16_mul_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_class(in_class),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_class(out_class),
      .flags_clear(flags_clear), .flag_invalid(flag_invalid), .flag_class_err(flag_class_err),
      .cnt_total(cnt_total), .cnt_nan(cnt_nan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkRegs();
      chk("out_valid_post", 16'(out_valid), 16'(expQ.size() != 0));
      chk("flag_invalid", 16'(flag_invalid), 16'(mInvalid));
      chk("flag_class_err", 16'(flag_class_err), 16'(mClassErr));
      chk("cnt_total", 16'(cnt_total), 16'(mTotal));
      chk("cnt_nan", 16'(cnt_nan), 16'(mNan));
   endtask

   // One clock: entered just after a falling edge, leaves at the next falling edge.
   task automatic cycle(input logic v, input logic [15:0] p, input logic [5:0] c,
                        input logic r, input logic clr, input logic rst);
      logic        doPush;
      logic        doPop;
      logic [21:0] e;
      reset = rst; in_valid = v; in_p = p; in_class = c; out_ready = r; flags_clear = clr;
      #1;
      chk("in_ready", 16'(in_ready), 16'(!rst && (expQ.size() < DEPTH)));
      chk("out_valid", 16'(out_valid), 16'(expQ.size() != 0));
      doPush = v && !rst && (expQ.size() < DEPTH);
      doPop  = r && !rst && (expQ.size() != 0);
      if (expQ.size() == 0) begin
         chk("out_p_idle", out_p, 16'h0000);
         chk("out_class_idle", 16'(out_class), 16'h0000);
      end
      if (doPop) begin
         e = expQ.pop_front();
         chk("out_p", out_p, e[21:6]);
         chk("out_class", 16'(out_class), 16'(e[5:0]));
      end
      if (rst) begin
         expQ.delete();
         mInvalid = 1'b0; mClassErr = 1'b0; mTotal = '0; mNan = '0;
      end else begin
         if (doPush)
            expQ.push_back(c[5] ? {p | 16'h0200, 6'b010000} : {p, c});
         mInvalid  = (mInvalid && !clr) || (doPush && c[5]);
         mClassErr = (mClassErr && !clr) || (doPush && ($countones(c) != 1));
         if (clr) begin
            mTotal = doPush ? 4'd1 : 4'd0;
            mNan   = (doPush && (c[5] || c[4])) ? 4'd1 : 4'd0;
         end else begin
            if (doPush && mTotal != 4'd15) mTotal = mTotal + 4'd1;
            if (doPush && (c[5] || c[4]) && mNan != 4'd15) mNan = mNan + 4'd1;
         end
      end
      @(posedge clk);
      #1;
      checkRegs();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_p = '0; in_class = '0; out_ready = 1'b0; flags_clear = 1'b0;
      mInvalid = 1'b0; mClassErr = 1'b0; mTotal = '0; mNan = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_out_valid", 16'(out_valid), 16'h0000);
      chk("reset_out_p", out_p, 16'h0000);
      chk("reset_in_ready", 16'(in_ready), 16'h0001);
      checkRegs();
      @(negedge clk);

      // Normal product, then sNaN quieting.
      cycle(1'b1, 16'h3C00, 6'b000001, 1'b0, 1'b0, 1'b0);
      chk("t1_cnt_total", 16'(cnt_total), 16'h0001);
      cycle(1'b0, 16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 16'h7D00, 6'b100000, 1'b0, 1'b0, 1'b0);
      chk("t2_out_p", out_p, 16'h7F00);
      chk("t2_out_class", 16'(out_class), 16'h0010);
      cycle(1'b0, 16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0);

      // Fill, refuse extra, drain across the pointer wrap.
      cycle(1'b1, 16'h1111, 6'b000001, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h2222, 6'b000010, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h3333, 6'b000100, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h3333, 6'b000100, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 16'h4444, 6'b001000, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0);

      // One entry held, concurrent push and pop.
      cycle(1'b1, 16'h5000, 6'b000001, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 16'($urandom_range(0, 65535)), 6'b000001, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0);

      // Clear concurrent with sNaN push: set wins; then clear alone.
      cycle(1'b1, 16'hFC01, 6'b100000, 1'b0, 1'b1, 1'b0);
      chk("t5_flag_invalid", 16'(flag_invalid), 16'h0001);
      chk("t5_cnt_nan", 16'(cnt_nan), 16'h0001);
      cycle(1'b0, 16'h0000, 6'b000000, 1'b1, 1'b1, 1'b0);

      // Malformed class, zero class, then reset with two entries held.
      cycle(1'b1, 16'h0001, 6'b000011, 1'b0, 1'b0, 1'b0);
      chk("t6_class_err", 16'(flag_class_err), 16'h0001);
      cycle(1'b1, 16'h0002, 6'b000000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h0003, 6'b000001, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0);

      // Saturation of both counters.
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 16'h7E00 + 16'(i), 6'b010000, 1'b1, 1'b0, 1'b0);
      chk("sat_cnt_total", 16'(cnt_total), 16'h000F);
      chk("sat_cnt_nan", 16'(cnt_nan), 16'h000F);
      cycle(1'b0, 16'h0000, 6'b000000, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
